// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC result writer.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  // Index widths never collapse to zero, so a dimension of 1 still gets a 1-bit port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_width(input int m);
    return idx_width(m);
  endfunction

  function automatic int col_width(input int n);
    return idx_width(n);
  endfunction

  function automatic int k_width(input int k);
    return idx_width(k);
  endfunction

  // A sum of K products of two W-bit operands fits in 2*W + clog2(K) bits.
  function automatic int result_width(input int w, input int k);
    return 2 * w + $clog2(k);
  endfunction

endpackage

// File: rtl/mac_wb_accum.sv
// R-bit accumulator with first-term load, last-term detect and the
// registered write-out stage feeding the result SRAM.
module mac_wb_accum
  import mac_pkg::*;
#(
  parameter int K  = 4,
  parameter int PW = 64,
  parameter int R  = 66,
  parameter int RW = 2,
  parameter int CW = 2,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          accept,
  input  logic [PW-1:0] prod_data,
  input  logic [RW-1:0] prod_row,
  input  logic [CW-1:0] prod_col,
  input  logic [KW-1:0] prod_k,
  output logic          last_term,
  output logic          c_we,
  output logic [RW-1:0] c_row_addr,
  output logic [CW-1:0] c_col_addr,
  output logic [R-1:0]  c_data
);

  logic [R-1:0] acc;
  logic [R-1:0] sum;

  assign last_term = (prod_k == KW'(K - 1));

  // A k==0 beat starts a fresh element, so the write of the previous one never stalls it.
  assign sum = (prod_k == '0) ? R'(prod_data) : acc + R'(prod_data);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= sum;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_we <= 1'b0;
    end else begin
      c_we <= accept && last_term;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_row_addr <= '0;
      c_col_addr <= '0;
      c_data     <= '0;
    end else if (accept && last_term) begin
      c_row_addr <= prod_row;
      c_col_addr <= prod_col;
      c_data     <= sum;
    end
  end

endmodule

// File: rtl/mac_result_writer.sv
// Sums K tagged products per C element and writes each result to the C SRAM.
// Defining MAC_WB_STATS_EN adds the wb_count and seq_err_cnt outputs.
module mac_result_writer
  import mac_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K),
  localparam int W  = DATA_WIDTH_INIT_MATRIX,
  localparam int R  = DATA_WIDTH_RESULT_MATRIX,
  localparam int RW = row_width(M),
  localparam int CW = col_width(N),
  localparam int KW = k_width(K),
  localparam int SW = $clog2(M * N + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           do_wb,
  input  logic           prod_valid,
  input  logic [2*W-1:0] prod_data,
  input  logic [RW-1:0]  prod_row,
  input  logic [CW-1:0]  prod_col,
  input  logic [KW-1:0]  prod_k,
  output logic           c_we,
  output logic [RW-1:0]  c_row_addr,
  output logic [CW-1:0]  c_col_addr,
  output logic [R-1:0]   c_data,
  output logic           wb_busy,
  output logic           wb_done,
  output logic           seq_err
`ifdef MAC_WB_STATS_EN
  ,
  output logic [SW-1:0]  wb_count,
  output logic [7:0]     seq_err_cnt
`endif
);

  wb_state_t     state, state_next;
  logic          start;
  logic          clear;
  logic          accept;
  logic          last_term;
  logic          seq_hit;
  logic [KW-1:0] exp_k;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Beats are only taken while running with do_wb still high; an abort drops them.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    clear      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (do_wb) begin
          state_next = RUN;
          start      = 1'b1;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (!do_wb) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else begin
          accept = prod_valid;
          if (prod_valid && last_term &&
              prod_row == RW'(M - 1) && prod_col == CW'(N - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!do_wb) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wb_busy = (state == RUN);
  assign wb_done = (state == DONE);
  assign seq_hit = accept && (prod_k != exp_k);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_k <= '0;
    end else if (clear) begin
      exp_k <= '0;
    end else if (accept) begin
      exp_k <= last_term ? '0 : KW'(prod_k + 1'b1);
    end
  end

  // Out-of-order beats are still summed at their tagged k; the flag only records the event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_err <= 1'b0;
    end else if (start) begin
      seq_err <= 1'b0;
    end else if (seq_hit) begin
      seq_err <= 1'b1;
    end
  end

  mac_wb_accum #(
    .K  (K),
    .PW (2 * W),
    .R  (R),
    .RW (RW),
    .CW (CW),
    .KW (KW)
  ) u_accum (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .accept     (accept),
    .prod_data  (prod_data),
    .prod_row   (prod_row),
    .prod_col   (prod_col),
    .prod_k     (prod_k),
    .last_term  (last_term),
    .c_we       (c_we),
    .c_row_addr (c_row_addr),
    .c_col_addr (c_col_addr),
    .c_data     (c_data)
  );

`ifdef MAC_WB_STATS_EN
  localparam logic [SW-1:0] WB_MAX = SW'(M * N);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_count <= '0;
    end else if (start) begin
      wb_count <= '0;
    end else if (accept && last_term && wb_count != WB_MAX) begin
      wb_count <= wb_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_err_cnt <= '0;
    end else if (seq_hit && seq_err_cnt != 8'hFF) begin
      seq_err_cnt <= seq_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_result_writer.sv
// Self-checking bench for mac_result_writer: three configurations (K=2, K=4, K=1)
// checked against a matrix-product reference model. Honours MAC_WB_STATS_EN.
module tb_mac_result_writer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned ma[4][4];
  int unsigned mb[4][4];

  // Instance A: M=N=K=2, W=8 (R=17)
  logic        a_do, a_valid;
  logic [15:0] a_data;
  logic [0:0]  a_row, a_col, a_k;
  logic        a_we, a_busy, a_done, a_serr;
  logic [0:0]  a_crow, a_ccol;
  logic [16:0] a_cdata;
  // Instance B: M=N=K=4, W=8 (R=18)
  logic        b_do, b_valid;
  logic [15:0] b_data;
  logic [1:0]  b_row, b_col, b_k;
  logic        b_we, b_busy, b_done, b_serr;
  logic [1:0]  b_crow, b_ccol;
  logic [17:0] b_cdata;
  // Instance C: M=N=2, K=1, W=8 (R=16)
  logic        c_do, c_valid;
  logic [15:0] c_data;
  logic [0:0]  c_row, c_col, c_k;
  logic        c_we, c_busy, c_done, c_serr;
  logic [0:0]  c_crow, c_ccol;
  logic [15:0] c_cdata;
`ifdef MAC_WB_STATS_EN
  logic [2:0]  a_cnt, c_cnt;
  logic [4:0]  b_cnt;
  logic [7:0]  a_scnt, b_scnt, c_scnt;
`endif

  mac_result_writer #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) u_a (
    .clk(clk), .resetn(resetn), .do_wb(a_do), .prod_valid(a_valid), .prod_data(a_data),
    .prod_row(a_row), .prod_col(a_col), .prod_k(a_k), .c_we(a_we), .c_row_addr(a_crow),
    .c_col_addr(a_ccol), .c_data(a_cdata), .wb_busy(a_busy), .wb_done(a_done), .seq_err(a_serr)
`ifdef MAC_WB_STATS_EN
    , .wb_count(a_cnt), .seq_err_cnt(a_scnt)
`endif
  );

  mac_result_writer #(.M(4), .K(4), .N(4), .DATA_WIDTH_INIT_MATRIX(8)) u_b (
    .clk(clk), .resetn(resetn), .do_wb(b_do), .prod_valid(b_valid), .prod_data(b_data),
    .prod_row(b_row), .prod_col(b_col), .prod_k(b_k), .c_we(b_we), .c_row_addr(b_crow),
    .c_col_addr(b_ccol), .c_data(b_cdata), .wb_busy(b_busy), .wb_done(b_done), .seq_err(b_serr)
`ifdef MAC_WB_STATS_EN
    , .wb_count(b_cnt), .seq_err_cnt(b_scnt)
`endif
  );

  mac_result_writer #(.M(2), .K(1), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) u_c (
    .clk(clk), .resetn(resetn), .do_wb(c_do), .prod_valid(c_valid), .prod_data(c_data),
    .prod_row(c_row), .prod_col(c_col), .prod_k(c_k), .c_we(c_we), .c_row_addr(c_crow),
    .c_col_addr(c_ccol), .c_data(c_cdata), .wb_busy(c_busy), .wb_done(c_done), .seq_err(c_serr)
`ifdef MAC_WB_STATS_EN
    , .wb_count(c_cnt), .seq_err_cnt(c_scnt)
`endif
  );

  // Reference: C[i][j] is the plain dot product of row i of A and column j of B.
  function automatic logic [63:0] ref_elem(input int i, input int j, input int kk);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < kk; k++) s += 64'(ma[i][k] * mb[k][j]);
    return s;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_a();
    a_do = 1'b1;
    step();
    check_output("a_busy_run", a_busy, 1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++) begin
          a_valid = 1'b1; a_row = 1'(i); a_col = 1'(j); a_k = 1'(k);
          a_data = 16'(ma[i][k] * mb[k][j]);
          step();
          if (k == 1) begin
            check_output("a_we", a_we, 1);
            check_output("a_row", a_crow, 64'(i));
            check_output("a_col", a_ccol, 64'(j));
            check_output("a_data", a_cdata, ref_elem(i, j, 2));
          end else begin
            check_output("a_we_idle", a_we, 0);
          end
        end
    check_output("a_done_last", a_done, 1);
    check_output("a_busy_last", a_busy, 0);
    a_row = 1'b0; a_col = 1'b0; a_k = 1'b0; a_data = 16'd99;
    step();
    check_output("a_we_in_done", a_we, 0);
    check_output("a_done_hold", a_done, 1);
`ifdef MAC_WB_STATS_EN
    check_output("a_wb_count", a_cnt, 4);
`endif
    a_valid = 1'b0; a_do = 1'b0;
    step();
    check_output("a_done_idle", a_done, 0);
  endtask

  task automatic apply_stimulus_b();
    b_do = 1'b1;
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          b_valid = 1'b1; b_row = 2'(i); b_col = 2'(j); b_k = 2'(k);
          b_data = 16'(ma[i][k] * mb[k][j]);
          step();
          if (k == 3) begin
            check_output("b_we", b_we, 1);
            check_output("b_addr", {b_crow, b_ccol}, 64'(i * 4 + j));
            check_output("b_data", b_cdata, ref_elem(i, j, 4));
          end else if (k == 0) begin
            check_output("b_we_idle", b_we, 0);
          end
        end
    b_valid = 1'b0;
    check_output("b_done_last", b_done, 1);
    check_output("b_serr_clean", b_serr, 0);
    b_do = 1'b0;
    step();
    check_output("b_done_idle", b_done, 0);
  endtask

  logic [63:0] exp_sum;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn = 1'b0;
    a_do = 0; a_valid = 0; a_data = 0; a_row = 0; a_col = 0; a_k = 0;
    b_do = 0; b_valid = 0; b_data = 0; b_row = 0; b_col = 0; b_k = 0;
    c_do = 0; c_valid = 0; c_data = 0; c_row = 0; c_col = 0; c_k = 0;
    step();
    step();
    check_output("rst_we", {a_we, b_we, c_we}, 0);
    check_output("rst_flags", {a_busy, a_done, a_serr, b_busy, b_done, b_serr}, 0);
    check_output("rst_data", b_cdata, 0);
    resetn = 1'b1;
    step();

    $display("[TB] 2x2 directed product");
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    check_output("ref_c00", ref_elem(0, 0, 2), 19);
    check_output("ref_c11", ref_elem(1, 1, 2), 50);
    apply_stimulus_a();

    $display("[TB] abort after 3 beats");
    a_do = 1'b1;
    step();
    for (int n = 0; n < 3; n++) begin
      a_valid = 1'b1; a_row = 1'b0; a_col = 1'(n / 2); a_k = 1'(n % 2);
      a_data = 16'(7 * (n + 1));
      step();
      if (n == 1) begin
        check_output("abort_we", a_we, 1);
        check_output("abort_data", a_cdata, 21);
      end else begin
        check_output("abort_we_idle", a_we, 0);
      end
    end
    a_valid = 1'b0; a_do = 1'b0;
    step();
    check_output("abort_busy", a_busy, 0);
    check_output("abort_we_off", a_we, 0);
    step();
    check_output("abort_no_write", a_we, 0);
    apply_stimulus_a();

    $display("[TB] all-255 operands, K=4");
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 255; mb[i][k] = 255;
      end
    apply_stimulus_b();
    check_output("b_max_value", b_cdata, 260100);

    for (int r = 0; r < 2; r++) begin
      $display("[TB] random run %0d", r);
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) begin
          ma[i][k] = $urandom_range(0, 255);
          mb[i][k] = $urandom_range(0, 255);
        end
      apply_stimulus_b();
    end

    $display("[TB] sequence error injection");
    b_do = 1'b1;
    step();
    exp_sum = '0;
    for (int k = 1; k < 4; k++) begin
      b_valid = 1'b1; b_row = 2'd0; b_col = 2'd0; b_k = 2'(k); b_data = 16'(10 * k);
      exp_sum += 64'(10 * k);
      step();
      if (k == 1) check_output("serr_set", b_serr, 1);
    end
    check_output("serr_write", b_we, 1);
    check_output("serr_data", b_cdata, exp_sum);
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1; b_row = 2'd0; b_col = 2'd1; b_k = 2'(k); b_data = 16'(k + 1);
      step();
    end
    check_output("serr_next_data", b_cdata, 10);
    b_valid = 1'b0; b_do = 1'b0;
    step();
    check_output("serr_sticky_idle", b_serr, 1);
`ifdef MAC_WB_STATS_EN
    check_output("serr_cnt", b_scnt, 1);
`endif
    b_do = 1'b1;
    step();
    check_output("serr_cleared", b_serr, 0);

    $display("[TB] reset during write");
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1; b_row = 2'd2; b_col = 2'd3; b_k = 2'(k); b_data = 16'd100;
      step();
    end
    check_output("rst_pre_we", b_we, 1);
    check_output("rst_pre_data", b_cdata, 400);
    #2 resetn = 1'b0;
    #1;
    check_output("rst_async_we", b_we, 0);
    check_output("rst_async_out", {b_crow, b_ccol, b_cdata, b_busy, b_done, b_serr}, 0);
`ifdef MAC_WB_STATS_EN
    check_output("rst_wb_count", b_cnt, 0);
`endif
    #2;
    b_valid = 1'b0; b_do = 1'b0;
    resetn = 1'b1;
    step();
    check_output("rst_idle", b_busy, 0);

    $display("[TB] K=1 back-to-back writes");
    c_do = 1'b1;
    step();
    for (int n = 0; n < 4; n++) begin
      c_valid = 1'b1; c_row = 1'(n / 2); c_col = 1'(n % 2); c_k = 1'b0;
      c_data = 16'(3 + 2 * n);
      step();
      check_output("k1_we", c_we, 1);
      check_output("k1_data", c_cdata, 64'(3 + 2 * n));
      check_output("k1_addr", {c_crow, c_ccol}, 64'(n));
    end
    c_valid = 1'b0;
    check_output("k1_done", c_done, 1);
    step();
    check_output("k1_we_off", c_we, 0);
    c_do = 1'b0;
    step();
    check_output("k1_idle", c_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
